// File: rtl/pmp_iter_checker.sv
// pmp_iter_checker: iterative PMP lookup that evaluates LANES entries per
// clock. The lowest-index entry that fully or partially covers the access
// wins. The first lane that hits, or the last group, ends the scan.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; ReqReady=1
// SCAN  | evaluating one group of LANES entries per clock
// DONE  | response presented (RspValid=1), held until RspReady
module pmp_iter_checker #(
    parameter int PA_BITS     = 56,
    parameter int PMP_ENTRIES = 16,
    parameter int LANES       = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ReqValid,
    output logic                                ReqReady,
    input  logic [PA_BITS-1:0]                  PhysicalAddress,
    input  logic [1:0]                          Size,
    input  logic [2:0]                          AccessType,
    input  logic [1:0]                          PrivilegeMode,
    input  logic [8*PMP_ENTRIES-1:0]            PMPCfgArray,
    input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0]  PMPAdrArray,
    output logic                                RspValid,
    input  logic                                RspReady,
    output logic                                RspFault,
    output logic                                RspMatched,
    output logic [$clog2(PMP_ENTRIES)-1:0]      RspMatchIdx
);

    localparam int AW = PA_BITS - 2;
    localparam int NG = PMP_ENTRIES / LANES;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int IW = $clog2(PMP_ENTRIES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PA_BITS-1:0]   r_pa;
    logic [1:0]           r_size;
    logic [2:0]           r_acc;
    logic [1:0]           r_priv;
    logic [GW-1:0]        r_g;
    logic                 r_fault;
    logic                 r_matched;
    logic [IW-1:0]        r_idx;

    logic                 w_accept;
    logic                 w_done_scan;
    logic                 w_rsp_fault;
    logic                 w_rsp_matched;
    logic [IW-1:0]        w_rsp_idx;

    logic [PA_BITS:0]     w_last_ext;
    logic [PA_BITS-1:0]   w_last;
    logic                 w_carry;
    logic                 w_mmode;
    logic                 w_last_grp;
    logic                 w_any_on;
    logic [IW-1:0]        w_base;

    logic [1:0]           w_ent_a    [PMP_ENTRIES];
    logic                 w_ent_lock [PMP_ENTRIES];
    logic [2:0]           w_ent_perm [PMP_ENTRIES];
    logic [AW-1:0]        w_ent_adr  [PMP_ENTRIES];

    logic [LANES-1:0]     w_hit;
    logic [LANES-1:0]     w_lfault;
    logic                 w_win;
    logic                 w_win_fault;
    logic [IW-1:0]        w_win_idx;

    // Region membership for one byte address. NAPOT mask = pmpaddr ^ (pmpaddr+1)
    // marks the trailing ones plus the first zero, i.e. the word offset bits;
    // an all-ones pmpaddr yields an all-ones mask and covers everything.
    function automatic logic f_in_region(input logic [PA_BITS-1:0] addr,
                                         input logic [1:0]         a,
                                         input logic [AW-1:0]      cur,
                                         input logic [AW-1:0]      prev);
        logic [AW-1:0] mask;
        logic          in_r;
        mask = cur ^ (cur + AW'(1));
        in_r = 1'b0;
        case (a)
            2'b01:   in_r = (addr >= {prev, 2'b00}) && (addr < {cur, 2'b00});
            2'b10:   in_r = (addr[PA_BITS-1:2] == cur);
            2'b11:   in_r = (((addr[PA_BITS-1:2] ^ cur) & ~mask) == '0);
            default: in_r = 1'b0;
        endcase
        return in_r;
    endfunction

    // Split the flat cfg/addr buses into per-entry fields.
    for (genvar e = 0; e < PMP_ENTRIES; e++) begin : g_ent
        logic w_unused_rsvd;
        assign w_ent_a[e]    = PMPCfgArray[e*8+3 +: 2];
        assign w_ent_lock[e] = PMPCfgArray[e*8+7];
        assign w_ent_perm[e] = PMPCfgArray[e*8 +: 3];
        assign w_ent_adr[e]  = PMPAdrArray[e*AW +: AW];
        assign w_unused_rsvd = ^PMPCfgArray[e*8+5 +: 2];
    end

    // Last byte at one extra bit so that wrapping past the top is detectable.
    assign w_last_ext = {1'b0, r_pa} + ((PA_BITS+1)'(1) << r_size) - (PA_BITS+1)'(1);
    assign w_last     = w_last_ext[PA_BITS-1:0];
    assign w_carry    = w_last_ext[PA_BITS];
    assign w_mmode    = (r_priv == 2'b11);
    assign w_last_grp = (r_g == GW'(NG-1));
    assign w_base     = IW'(r_g) * IW'(LANES);

    // Per-lane match and fault evaluation for the current group.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IW-1:0] w_idx;
        logic [IW-1:0] w_pidx;
        logic [AW-1:0] w_prev;
        logic          w_first_in;
        logic          w_last_in;
        assign w_idx      = w_base + IW'(l);
        assign w_pidx     = w_idx - IW'(1);
        assign w_prev     = (w_idx == '0) ? '0 : w_ent_adr[w_pidx];
        assign w_first_in = f_in_region(r_pa,   w_ent_a[w_idx], w_ent_adr[w_idx], w_prev);
        assign w_last_in  = f_in_region(w_last, w_ent_a[w_idx], w_ent_adr[w_idx], w_prev);
        assign w_hit[l]   = (w_ent_a[w_idx] != 2'b00) && (w_first_in || w_last_in);
        assign w_lfault[l] = (w_first_in != w_last_in)          ? 1'b1 :
                             (w_mmode && !w_ent_lock[w_idx])    ? 1'b0 :
                             ~|(r_acc & w_ent_perm[w_idx]);
    end

    // Lowest hitting lane wins; scanned high-to-low so the lowest overwrites.
    always_comb begin
        w_win       = 1'b0;
        w_win_fault = 1'b0;
        w_win_idx   = '0;
        for (int l = LANES-1; l >= 0; l--) begin
            if (w_hit[l]) begin
                w_win       = 1'b1;
                w_win_fault = w_lfault[l];
                w_win_idx   = w_base + IW'(l);
            end
        end
    end

    // Any configured entry makes an unmatched S/U access fault.
    always_comb begin
        w_any_on = 1'b0;
        for (int e = 0; e < PMP_ENTRIES; e++) begin
            w_any_on = w_any_on | (|w_ent_a[e]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state, handshake and response selection.
    always_comb begin
        w_state_nxt   = r_state;
        ReqReady      = 1'b0;
        w_done_scan   = 1'b0;
        w_rsp_fault   = 1'b0;
        w_rsp_matched = 1'b0;
        w_rsp_idx     = '0;
        case (r_state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_carry) begin
                    w_done_scan = 1'b1;
                    w_rsp_fault = 1'b1;
                end else if (w_win) begin
                    w_done_scan   = 1'b1;
                    w_rsp_fault   = w_win_fault;
                    w_rsp_matched = 1'b1;
                    w_rsp_idx     = w_win_idx;
                end else if (w_last_grp) begin
                    w_done_scan = 1'b1;
                    w_rsp_fault = !w_mmode && w_any_on;
                end
                if (w_done_scan) w_state_nxt = DONE;
            end
            DONE: begin
                if (RspReady) begin
                    ReqReady    = 1'b1;
                    w_state_nxt = ReqValid ? SCAN : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = ReqValid & ReqReady;

    // Request capture, group counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pa      <= '0;
            r_size    <= '0;
            r_acc     <= '0;
            r_priv    <= '0;
            r_g       <= '0;
            r_fault   <= 1'b0;
            r_matched <= 1'b0;
            r_idx     <= '0;
        end else begin
            if (w_accept) begin
                r_pa   <= PhysicalAddress;
                r_size <= Size;
                r_acc  <= AccessType;
                r_priv <= PrivilegeMode;
                r_g    <= '0;
            end else if (r_state == SCAN) begin
                r_g <= r_g + GW'(1);
            end
            if (w_done_scan) begin
                r_fault   <= w_rsp_fault;
                r_matched <= w_rsp_matched;
                r_idx     <= w_rsp_idx;
            end
        end
    end

    assign RspValid    = (r_state == DONE);
    assign RspFault    = r_fault;
    assign RspMatched  = r_matched;
    assign RspMatchIdx = r_idx;

endmodule

// File: tb/tb_pmp_iter_checker.sv
// Directed bench for pmp_iter_checker: a table of single-request vectors
// plus hand-written sequences for hold, back-to-back and mid-scan reset.
module tb_pmp_iter_checker;

    localparam int PA = 56;
    localparam int NE = 16;
    localparam int AW = PA - 2;

    localparam logic [2:0] R = 3'b001;
    localparam logic [2:0] W = 3'b010;
    localparam logic [2:0] X = 3'b100;
    localparam logic [1:0] PM = 2'b11;
    localparam logic [1:0] PS = 2'b01;
    localparam logic [1:0] PU = 2'b00;
    localparam logic [AW-1:0] AONES = {AW{1'b1}};
    localparam logic [PA-1:0] PONES = {PA{1'b1}};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ReqValid = 1'b0;
    logic              ReqReady;
    logic [PA-1:0]     PhysicalAddress = '0;
    logic [1:0]        Size = '0;
    logic [2:0]        AccessType = '0;
    logic [1:0]        PrivilegeMode = '0;
    logic [8*NE-1:0]   PMPCfgArray;
    logic [AW*NE-1:0]  PMPAdrArray;
    logic              RspValid;
    logic              RspReady = 1'b0;
    logic              RspFault;
    logic              RspMatched;
    logic [3:0]        RspMatchIdx;

    logic [7:0]        tb_cfg [NE];
    logic [AW-1:0]     tb_adr [NE];

    int n_tests = 0;
    int n_fail  = 0;

    pmp_iter_checker dut (
        .clk             (clk),
        .reset           (reset),
        .ReqValid        (ReqValid),
        .ReqReady        (ReqReady),
        .PhysicalAddress (PhysicalAddress),
        .Size            (Size),
        .AccessType      (AccessType),
        .PrivilegeMode   (PrivilegeMode),
        .PMPCfgArray     (PMPCfgArray),
        .PMPAdrArray     (PMPAdrArray),
        .RspValid        (RspValid),
        .RspReady        (RspReady),
        .RspFault        (RspFault),
        .RspMatched      (RspMatched),
        .RspMatchIdx     (RspMatchIdx)
    );

    always #5 clk = ~clk;

    always_comb begin
        PMPCfgArray = '0;
        PMPAdrArray = '0;
        for (int e = 0; e < NE; e++) begin
            PMPCfgArray[e*8 +: 8]   = tb_cfg[e];
            PMPAdrArray[e*AW +: AW] = tb_adr[e];
        end
    end

    typedef struct {
        logic [3:0]    ent;
        logic [7:0]    cfg;
        logic [AW-1:0] adr;
        logic          has2;
        logic [3:0]    ent2;
        logic [7:0]    cfg2;
        logic [AW-1:0] adr2;
        logic [PA-1:0] pa;
        logic [1:0]    size;
        logic [2:0]    acc;
        logic [1:0]    priv;
        logic          fault;
        logic          matched;
        logic [3:0]    idx;
        int            lat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [3:0] ent, logic [7:0] cfg, logic [AW-1:0] adr,
                                logic has2, logic [3:0] ent2, logic [7:0] cfg2,
                                logic [AW-1:0] adr2, logic [PA-1:0] pa, logic [1:0] size,
                                logic [2:0] acc, logic [1:0] priv, logic fault,
                                logic matched, logic [3:0] idx, int lat);
        vec_t v;
        v.ent = ent;   v.cfg = cfg;   v.adr = adr;
        v.has2 = has2; v.ent2 = ent2; v.cfg2 = cfg2; v.adr2 = adr2;
        v.pa = pa;     v.size = size; v.acc = acc;   v.priv = priv;
        v.fault = fault; v.matched = matched; v.idx = idx; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int e = 0; e < NE; e++) begin
            tb_cfg[e] = '0;
            tb_adr[e] = '0;
        end
    endtask

    task automatic apply_cfg(input vec_t v);
        clear_cfg();
        tb_cfg[v.ent] = v.cfg;
        tb_adr[v.ent] = v.adr;
        if (v.has2) begin
            tb_cfg[v.ent2] = v.cfg2;
            tb_adr[v.ent2] = v.adr2;
        end
    endtask

    // Starts and ends at a negedge; returns just after the accept edge.
    task automatic start_req(input logic [PA-1:0] pa, input logic [1:0] sz,
                             input logic [2:0] acc, input logic [1:0] priv);
        PhysicalAddress = pa;
        Size            = sz;
        AccessType      = acc;
        PrivilegeMode   = priv;
        ReqValid        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
    endtask

    // Counts accept-to-RspValid clocks, bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!RspValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_rsp();
        RspReady = 1'b1;
        @(negedge clk);
        RspReady = 1'b0;
    endtask

    initial begin
        int lat;
        vec_t v;

        clear_cfg();
        // ent cfg adr | has2 ent2 cfg2 adr2 | pa size acc priv | fault matched idx lat
        vq.push_back(mk(5, 8'h1B, 54'h41FF, 0, 0, 8'h00, 54'h0,   56'h10100,    2, R, PS, 1'b0, 1'b1, 5, 2));
        vq.push_back(mk(5, 8'h1B, 54'h41FF, 0, 0, 8'h00, 54'h0,   56'h10FFC,    3, R, PS, 1'b1, 1'b1, 5, 2));
        vq.push_back(mk(0, 8'h09, 54'h400,  0, 0, 8'h00, 54'h0,   56'h800,      0, W, PU, 1'b1, 1'b1, 0, 1));
        vq.push_back(mk(0, 8'h09, 54'h400,  0, 0, 8'h00, 54'h0,   56'h800,      0, R, PU, 1'b0, 1'b1, 0, 1));
        vq.push_back(mk(15, 8'h11, 54'h0,   0, 0, 8'h00, 54'h0,   56'h80000000, 0, R, PM, 1'b0, 1'b0, 0, 4));
        vq.push_back(mk(15, 8'h11, 54'h0,   0, 0, 8'h00, 54'h0,   56'h80000000, 0, R, PU, 1'b1, 1'b0, 0, 4));
        vq.push_back(mk(3, 8'h98, 54'h41FF, 0, 0, 8'h00, 54'h0,   56'h10100,    2, R, PM, 1'b1, 1'b1, 3, 1));
        vq.push_back(mk(3, 8'h18, 54'h41FF, 0, 0, 8'h00, 54'h0,   56'h10100,    2, R, PM, 1'b0, 1'b1, 3, 1));
        vq.push_back(mk(0, 8'h00, 54'h0,    0, 0, 8'h00, 54'h0,   56'h123,      0, R, PU, 1'b0, 1'b0, 0, 4));
        vq.push_back(mk(0, 8'h1F, AONES,    0, 0, 8'h00, 54'h0,   PONES,        3, R, PM, 1'b1, 1'b0, 0, 1));
        vq.push_back(mk(0, 8'h1F, AONES,    0, 0, 8'h00, 54'h0,   PONES,        0, R, PU, 1'b0, 1'b1, 0, 1));
        vq.push_back(mk(2, 8'h11, 54'h100,  0, 0, 8'h00, 54'h0,   56'h402,      1, R, PS, 1'b0, 1'b1, 2, 1));
        vq.push_back(mk(2, 8'h11, 54'h100,  0, 0, 8'h00, 54'h0,   56'h403,      1, R, PS, 1'b1, 1'b1, 2, 1));
        vq.push_back(mk(1, 8'h0F, 54'h100,  1, 0, 8'h00, 54'h200, 56'h500,      0, R, PU, 1'b1, 1'b0, 0, 4));
        vq.push_back(mk(1, 8'h0F, 54'h200,  1, 0, 8'h00, 54'h100, 56'h7FF,      0, X, PU, 1'b0, 1'b1, 1, 1));
        vq.push_back(mk(1, 8'h0F, 54'h200,  1, 0, 8'h00, 54'h100, 56'h800,      0, R, PU, 1'b1, 1'b0, 0, 4));
        vq.push_back(mk(1, 8'h0F, 54'h200,  1, 0, 8'h00, 54'h100, 56'h7FF,      1, R, PU, 1'b1, 1'b1, 1, 1));
        vq.push_back(mk(2, 8'h1F, 54'h41FF, 1, 1, 8'h18, 54'h41FF, 56'h10100,   2, R, PS, 1'b1, 1'b1, 1, 1));
        vq.push_back(mk(6, 8'h1F, 54'h41FF, 1, 5, 8'h18, 54'h41FF, 56'h10100,   2, R, PS, 1'b1, 1'b1, 5, 2));
        vq.push_back(mk(5, 8'h1B, 54'h41FF, 0, 0, 8'h00, 54'h0,   56'h10100,    2, W, PU, 1'b0, 1'b1, 5, 2));
        vq.push_back(mk(7, 8'h1B, 54'h41FF, 0, 0, 8'h00, 54'h0,   56'h10100,    2, X, PS, 1'b1, 1'b1, 7, 2));

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ReqReady",  64'(ReqReady),    64'd1);
        chk("rst.RspValid",  64'(RspValid),    64'd0);
        chk("rst.RspFault",  64'(RspFault),    64'd0);
        chk("rst.RspMatched", 64'(RspMatched), 64'd0);
        chk("rst.RspMatchIdx", 64'(RspMatchIdx), 64'd0);

        // Table vectors
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            apply_cfg(v);
            start_req(v.pa, v.size, v.acc, v.priv);
            wait_rsp(lat);
            chk($sformatf("v%0d.lat", i),     64'(lat),         64'(v.lat));
            chk($sformatf("v%0d.fault", i),   64'(RspFault),    64'(v.fault));
            chk($sformatf("v%0d.matched", i), 64'(RspMatched),  64'(v.matched));
            chk($sformatf("v%0d.idx", i),     64'(RspMatchIdx), 64'(v.idx));
            release_rsp();
        end

        // Carry-out response held stable while RspReady stays low
        clear_cfg();
        start_req(PONES, 2'd3, R, PM);
        wait_rsp(lat);
        chk("hold.lat", 64'(lat), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d.valid", c),   64'(RspValid),    64'd1);
            chk($sformatf("hold%0d.fault", c),   64'(RspFault),    64'd1);
            chk($sformatf("hold%0d.matched", c), 64'(RspMatched),  64'd0);
            chk($sformatf("hold%0d.idx", c),     64'(RspMatchIdx), 64'd0);
            chk($sformatf("hold%0d.ready", c),   64'(ReqReady),    64'd0);
        end
        release_rsp();

        // Back-to-back: new request accepted on the same edge as the response
        clear_cfg();
        tb_cfg[5] = 8'h1B;
        tb_adr[5] = 54'h41FF;
        start_req(56'h10100, 2'd2, R, PS);
        wait_rsp(lat);
        chk("b2b.first.lat",   64'(lat),      64'd2);
        chk("b2b.first.fault", 64'(RspFault), 64'd0);
        PhysicalAddress = 56'h10FFC;
        Size            = 2'd3;
        ReqValid        = 1'b1;
        RspReady        = 1'b1;
        #1;
        chk("b2b.ReqReady", 64'(ReqReady), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ReqValid = 1'b0;
        RspReady = 1'b0;
        chk("b2b.scan.valid", 64'(RspValid), 64'd0);
        wait_rsp(lat);
        chk("b2b.second.lat",     64'(lat),         64'd2);
        chk("b2b.second.fault",   64'(RspFault),    64'd1);
        chk("b2b.second.matched", 64'(RspMatched),  64'd1);
        chk("b2b.second.idx",     64'(RspMatchIdx), 64'd5);
        release_rsp();
        chk("b2b.idle.ready", 64'(ReqReady), 64'd1);

        // Reset in the middle of a scan aborts the request
        clear_cfg();
        tb_cfg[15] = 8'h11;
        start_req(56'h80000000, 2'd0, R, PM);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst.valid", 64'(RspValid), 64'd0);
        chk("midrst.ready", 64'(ReqReady), 64'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("midrst%0d.valid", c), 64'(RspValid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
